// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: exception codes, register indices, field positions.
// No logic and no state; only types, constants and packing helpers.
// Not applicable: nothing here carries a handshake.
package cp0_unit_pkg;

    // Exception codes reported by the M-stage detector
    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // CP0 register indices used by mfc0/mtc0
    typedef enum logic [4:0] {
        CP0_SR    = 5'd12,
        CP0_CAUSE = 5'd13,
        CP0_EPC   = 5'd14,
        CP0_PRID  = 5'd15
    } cp0_idx_e;

    // Field positions inside SR and Cause
    localparam int IM_HI   = 15;
    localparam int IM_LO   = 10;
    localparam int EXL_BIT = 1;
    localparam int IE_BIT  = 0;
    localparam int BD_BIT  = 31;
    localparam int EXC_HI  = 6;
    localparam int EXC_LO  = 2;

    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    typedef struct packed {
        logic       bd;
        logic [5:0] ip;
        logic [4:0] exccode;
    } cause_t;

    // SR as software sees it; unimplemented bits read 0
    function automatic logic [31:0] pack_sr(input sr_t s);
        logic [31:0] w;
        w                = '0;
        w[IM_HI:IM_LO]   = s.im;
        w[EXL_BIT]       = s.exl;
        w[IE_BIT]        = s.ie;
        return w;
    endfunction

    // Cause as software sees it; IP shares the IM bit positions
    function automatic logic [31:0] pack_cause(input cause_t c);
        logic [31:0] w;
        w                = '0;
        w[BD_BIT]        = c.bd;
        w[IM_HI:IM_LO]   = c.ip;
        w[EXC_HI:EXC_LO] = c.exccode;
        return w;
    endfunction

endpackage

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR/Cause/EPC/PRId, exception vs interrupt arbitration, mfc0/mtc0/eret.
// int_req and dout are combinational in the request cycle; register updates show one cycle later.
// No backpressure: int_req flushes F..M, and any same-cycle mtc0/eret is dropped and replayed after return.
module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter logic [31:0] PRID         = 32'h4D49_5053,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_m,
    input  logic [4:0]  exccode_m,
    input  logic        bd_m,
    input  logic [5:0]  hwint,
    input  logic        we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] din,
    input  logic        eret_m,
    output logic [31:0] dout,
    output logic [31:0] epc_out,
    output logic        int_req,
    output logic [31:0] handler_pc
);

    sr_t         sr_q;
    cause_t      cause_q;
    logic [31:2] epc_q;

    logic        irq;
    logic        exc;
    logic [31:2] epc_next;
    logic        unused_pc_low;

    // PC bits [1:0] are always dropped when forming EPC
    assign unused_pc_low = ^pc_m[1:0];

    // Request arbitration: EXL masks everything; an interrupt outranks an exception
    always_comb begin
        irq      = (|(hwint & sr_q.im)) & sr_q.ie & ~sr_q.exl;
        exc      = (exccode_m != 5'd0) & ~sr_q.exl;
        int_req  = irq | exc;
        // Delay-slot faults return to the branch so it is re-executed
        epc_next = bd_m ? (pc_m[31:2] - 30'd1) : pc_m[31:2];
    end

    // CP0 register state: exception entry wins over mtc0/eret; eret clears EXL after any SR write
    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_q    <= '0;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            cause_q.ip <= hwint;
            if (int_req) begin
                sr_q.exl        <= 1'b1;
                cause_q.bd      <= bd_m;
                cause_q.exccode <= irq ? EXC_INT : exccode_m;
                epc_q           <= epc_next;
            end else begin
                if (we && (cp0_addr == CP0_SR)) begin
                    sr_q.im  <= din[IM_HI:IM_LO];
                    sr_q.exl <= din[EXL_BIT];
                    sr_q.ie  <= din[IE_BIT];
                end
                if (we && (cp0_addr == CP0_EPC)) begin
                    epc_q <= din[31:2];
                end
                if (eret_m) begin
                    sr_q.exl <= 1'b0;
                end
            end
        end
    end

    // mfc0 read mux; unimplemented indices read 0
    always_comb begin
        dout = 32'd0;
        case (cp0_addr)
            CP0_SR:    dout = pack_sr(sr_q);
            CP0_CAUSE: dout = pack_cause(cause_q);
            CP0_EPC:   dout = {epc_q, 2'b00};
            CP0_PRID:  dout = PRID;
            default:   dout = 32'd0;
        endcase
    end

    assign epc_out    = {epc_q, 2'b00};
    assign handler_pc = HANDLER_ADDR;

endmodule
